// File: rtl/wb_mem_arbiter_if.sv
// Single Wishbone-style request/response channel, used for both master
// ports and the shared slave port of wb_mem_arbiter.
interface wb_mem_arbiter_if;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  sel;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (output stb, we, addr, wdata, sel, input  ack, stall, rdata);
  modport slave  (input  stb, we, addr, wdata, sel, output ack, stall, rdata);
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave Wishbone arbiter: one pending request per master,
// round-robin issue, timeout forces an error completion on a dead slave.
module wb_mem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  wb_mem_arbiter_if.slave  m0,
  wb_mem_arbiter_if.slave  m1,
  wb_mem_arbiter_if.master s,
  output logic             o_timeout,
  output logic             o_proto_err
);
  localparam int NUM_M = 2;
  localparam int CW    = 10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [NUM_M-1:0]       m_stb, m_we, pend, cap_we, done, ack, perr;
  logic [NUM_M-1:0][31:0] m_addr, m_wdata, cap_addr, cap_wdata, rdata;
  logic [NUM_M-1:0][2:0]  m_sel, cap_sel;
  logic [31:0]            fin_data;

  assign m_stb   = {m1.stb,   m0.stb};
  assign m_we    = {m1.we,    m0.we};
  assign m_addr  = {m1.addr,  m0.addr};
  assign m_wdata = {m1.wdata, m0.wdata};
  assign m_sel   = {m1.sel,   m0.sel};

  assign m0.ack   = ack[0];
  assign m0.stall = pend[0];
  assign m0.rdata = rdata[0];
  assign m1.ack   = ack[1];
  assign m1.stall = pend[1];
  assign m1.rdata = rdata[1];

  // Per-master capture: completion and new capture never collide because
  // completion only happens while pending is set, which blocks capture.
  generate
    for (genvar i = 0; i < NUM_M; i++) begin : g_port
      logic        pend_q, we_q, ack_q;
      logic [31:0] addr_q, wdata_q, rdata_q;
      logic [2:0]  sel_q;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          pend_q  <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          sel_q   <= 3'b010;
          ack_q   <= 1'b0;
          rdata_q <= 32'hFFFFFFFF;
        end else begin
          ack_q <= done[i];
          if (done[i]) begin
            rdata_q <= fin_data;
            pend_q  <= 1'b0;
          end else if (m_stb[i] && !pend_q) begin
            pend_q  <= 1'b1;
            we_q    <= m_we[i];
            addr_q  <= m_addr[i];
            wdata_q <= m_wdata[i];
            sel_q   <= m_sel[i];
          end
        end
      end

      assign pend[i]      = pend_q;
      assign cap_we[i]    = we_q;
      assign cap_addr[i]  = addr_q;
      assign cap_wdata[i] = wdata_q;
      assign cap_sel[i]   = sel_q;
      assign ack[i]       = ack_q;
      assign rdata[i]     = rdata_q;
      assign perr[i]      = m_stb[i] & pend_q;
    end
  endgenerate

  state_t          state;
  logic            grant, last_grant, pick, fin, hit_to;
  logic [CW-1:0]   cnt;
  logic            s_stb_q, s_we_q;
  logic [31:0]     s_addr_q, s_wdata_q;
  logic [2:0]      s_sel_q;

  // Tie goes to the master that did not win last time.
  assign pick     = (&pend) ? ~last_grant : pend[1];
  assign hit_to   = (cnt == CW'(TIMEOUT - 1));
  assign fin      = (state == S_WAIT) && (s.ack || hit_to);
  assign fin_data = s.ack ? s.rdata : ERR_DATA;
  assign done     = fin ? (NUM_M'(1) << grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      s_stb_q     <= 1'b0;
      s_we_q      <= 1'b0;
      s_addr_q    <= 32'hFFFFFFFF;
      s_wdata_q   <= 32'hFFFFFFFF;
      s_sel_q     <= 3'b010;
      o_timeout   <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      s_stb_q <= 1'b0;
      if (|perr) o_proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if ((|pend) && !s.stall) begin
            grant     <= pick;
            s_stb_q   <= 1'b1;
            s_we_q    <= cap_we[pick];
            s_addr_q  <= cap_addr[pick];
            s_wdata_q <= cap_wdata[pick];
            s_sel_q   <= cap_sel[pick];
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fin) begin
            last_grant <= grant;
            state      <= S_IDLE;
            if (!s.ack) o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s.stb   = s_stb_q;
  assign s.we    = s_we_q;
  assign s.addr  = s_addr_q;
  assign s.wdata = s_wdata_q;
  assign s.sel   = s_sel_q;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: arbitration order, latency, dropped
// strobes, timeout, slave stall and reset in the middle of a transaction.
module tb_wb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout, proto_err;

  wb_mem_arbiter_if m0_bus();
  wb_mem_arbiter_if m1_bus();
  wb_mem_arbiter_if s_bus();

  wb_mem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hFFFFFFFF)) dut (
    .i_clk(clk), .i_reset(rst),
    .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .o_timeout(timeout), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int n_sstb = 0, n_m0ack = 0, n_m1ack = 0;
  logic [31:0] seen_addr, seen_wd;
  logic        seen_we;
  logic [2:0]  seen_sel;

  always @(negedge clk) begin
    if (s_bus.stb === 1'b1)  n_sstb  <= n_sstb + 1;
    if (m0_bus.ack === 1'b1) n_m0ack <= n_m0ack + 1;
    if (m1_bus.ack === 1'b1) n_m1ack <= n_m1ack + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic req(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] sel);
    if (m == 0) begin
      m0_bus.stb = 1'b1; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wd; m0_bus.sel = sel;
    end else begin
      m1_bus.stb = 1'b1; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wd; m1_bus.sel = sel;
    end
  endtask

  task automatic drop;
    m0_bus.stb = 1'b0;
    m1_bus.stb = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
  endtask

  // Zero-wait slave: acks on the cycle after it sees stb; returns in the
  // cycle where the master ack is expected.
  task automatic serve(input logic [31:0] rd, output int waited);
    waited = 0;
    while (s_bus.stb !== 1'b1 && waited < 40) begin tick; waited++; end
    seen_addr = s_bus.addr; seen_sel = s_bus.sel; seen_we = s_bus.we; seen_wd = s_bus.wdata;
    tick;
    chk("s_stb_single_cycle", s_bus.stb, 0);
    s_bus.ack = 1'b1; s_bus.rdata = rd;
    tick;
    s_bus.ack = 1'b0;
  endtask

  initial begin
    int w, n;
    logic saw;
    m0_bus.stb = 0; m0_bus.we = 0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.sel = 0;
    m1_bus.stb = 0; m1_bus.we = 0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.sel = 0;
    s_bus.ack = 0; s_bus.stall = 0; s_bus.rdata = 0;

    // Reset values
    do_reset;
    chk("rst_m0_ack", m0_bus.ack, 0);     chk("rst_m1_ack", m1_bus.ack, 0);
    chk("rst_m0_stall", m0_bus.stall, 0); chk("rst_m1_stall", m1_bus.stall, 0);
    chk("rst_s_stb", s_bus.stb, 0);       chk("rst_s_we", s_bus.we, 0);
    chk("rst_s_addr", s_bus.addr, 32'hFFFFFFFF);
    chk("rst_s_data", s_bus.wdata, 32'hFFFFFFFF);
    chk("rst_s_sel", s_bus.sel, 3'b010);
    chk("rst_m0_data", m0_bus.rdata, 32'hFFFFFFFF);
    chk("rst_m1_data", m1_bus.rdata, 32'hFFFFFFFF);
    chk("rst_timeout", timeout, 0);       chk("rst_proto", proto_err, 0);

    // Single m0 read of 0x10
    req(0, 0, 32'h10, 0, 3'b010); tick; drop;
    chk("rd_stall_set", m0_bus.stall, 1);
    serve(32'hDEADBEEF, w);
    chk("rd_issue_latency", w, 1);
    chk("rd_s_addr", seen_addr, 32'h10); chk("rd_s_sel", seen_sel, 3'b010); chk("rd_s_we", seen_we, 0);
    chk("rd_m0_ack", m0_bus.ack, 1);     chk("rd_m0_data", m0_bus.rdata, 32'hDEADBEEF);
    chk("rd_m0_stall_clr", m0_bus.stall, 0); chk("rd_m1_no_ack", m1_bus.ack, 0);
    tick;
    chk("rd_m0_ack_pulse", m0_bus.ack, 0);
    tick;
    chk("rd_m1_ack_count", n_m1ack, 0);  chk("rd_sstb_count", n_sstb, 1);

    // Simultaneous pair from reset: m0 wins
    do_reset;
    req(0, 0, 32'h0, 0, 3'b010); req(1, 1, 32'h4, 32'h55, 3'b010); tick; drop;
    serve(32'h01234567, w);
    chk("pair1_first_lat", w, 1);   chk("pair1_first_addr", seen_addr, 32'h0); chk("pair1_first_we", seen_we, 0);
    chk("pair1_m0_ack", m0_bus.ack, 1); chk("pair1_m0_data", m0_bus.rdata, 32'h01234567);
    chk("pair1_m1_waiting", m1_bus.stall, 1);
    serve(32'h600DF00D, w);
    chk("pair1_second_lat", w, 1);  chk("pair1_second_addr", seen_addr, 32'h4);
    chk("pair1_second_we", seen_we, 1); chk("pair1_second_wd", seen_wd, 32'h55);
    chk("pair1_m1_ack", m1_bus.ack, 1); chk("pair1_m1_data", m1_bus.rdata, 32'h600DF00D);
    chk("pair1_m0_data_held", m0_bus.rdata, 32'h01234567);
    tick;
    // m0 alone, so m0 becomes the last winner
    req(0, 0, 32'h8, 0, 3'b010); tick; drop;
    serve(32'h11111111, w);
    chk("solo_m0_ack", m0_bus.ack, 1);
    tick;
    // Second simultaneous pair: m1 wins
    req(0, 0, 32'h14, 0, 3'b010); req(1, 1, 32'hC, 32'hAB, 3'b001); tick; drop;
    serve(32'h22222222, w);
    chk("pair2_first_addr", seen_addr, 32'hC); chk("pair2_first_sel", seen_sel, 3'b001);
    chk("pair2_m1_ack", m1_bus.ack, 1);        chk("pair2_m0_no_ack", m0_bus.ack, 0);
    serve(32'h33333333, w);
    chk("pair2_second_addr", seen_addr, 32'h14);
    chk("pair2_m0_ack", m0_bus.ack, 1);        chk("pair2_m0_data", m0_bus.rdata, 32'h33333333);
    chk("pair_proto_clear", proto_err, 0);
    tick;

    // m1 double strobe two cycles apart: second is dropped
    n_sstb = 0; n_m0ack = 0; n_m1ack = 0;
    tick;
    req(1, 0, 32'h40, 0, 3'b010); tick; drop;
    tick;
    chk("dbl_s_stb", s_bus.stb, 1); chk("dbl_s_addr", s_bus.addr, 32'h40);
    req(1, 0, 32'h44, 0, 3'b010); tick; drop;
    chk("dbl_proto_err", proto_err, 1);
    s_bus.ack = 1'b1; s_bus.rdata = 32'h44444444; tick; s_bus.ack = 1'b0;
    chk("dbl_m1_ack", m1_bus.ack, 1); chk("dbl_m1_data", m1_bus.rdata, 32'h44444444);
    tick; tick; tick;
    chk("dbl_sstb_count", n_sstb, 1); chk("dbl_m1_ack_count", n_m1ack, 1);
    chk("dbl_m1_stall", m1_bus.stall, 0); chk("dbl_proto_sticky", proto_err, 1);

    // Dead slave: timeout after 8 cycles in wait
    req(0, 0, 32'h20, 0, 3'b010); tick; drop;
    tick;
    chk("to_s_stb", s_bus.stb, 1);
    n = 0;
    while (m0_bus.ack !== 1'b1 && n < 30) begin tick; n++; end
    chk("to_cycles", n, 8);
    chk("to_m0_data", m0_bus.rdata, 32'hFFFFFFFF); chk("to_flag", timeout, 1);
    tick;
    chk("to_ack_pulse", m0_bus.ack, 0);
    req(0, 0, 32'h24, 0, 3'b010); tick; drop;
    serve(32'h5A5A5A5A, w);
    chk("to_next_ack", m0_bus.ack, 1); chk("to_next_data", m0_bus.rdata, 32'h5A5A5A5A);
    chk("to_flag_sticky", timeout, 1);
    tick;

    // Slave stall held 5 cycles
    s_bus.stall = 1'b1;
    req(0, 0, 32'h30, 0, 3'b010); tick; drop;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin tick; if (s_bus.stb === 1'b1) saw = 1'b1; end
    chk("stall_no_issue", saw, 0);
    s_bus.stall = 1'b0;
    serve(32'h77777777, w);
    chk("stall_issue_lat", w, 1); chk("stall_addr", seen_addr, 32'h30);
    chk("stall_m0_ack", m0_bus.ack, 1); chk("stall_m0_data", m0_bus.rdata, 32'h77777777);
    tick;

    // Reset while waiting, then a late slave ack
    n_m0ack = 0;
    req(0, 0, 32'h50, 0, 3'b010); tick; drop;
    tick;
    chk("rw_s_stb", s_bus.stb, 1);
    rst = 1'b1; tick; rst = 1'b0;
    s_bus.ack = 1'b1; s_bus.rdata = 32'h99999999; tick; s_bus.ack = 1'b0;
    chk("rw_m0_ack", m0_bus.ack, 0);      chk("rw_m1_ack", m1_bus.ack, 0);
    chk("rw_m0_stall", m0_bus.stall, 0);  chk("rw_s_stb_low", s_bus.stb, 0);
    chk("rw_s_addr", s_bus.addr, 32'hFFFFFFFF); chk("rw_s_sel", s_bus.sel, 3'b010);
    chk("rw_m0_data", m0_bus.rdata, 32'hFFFFFFFF);
    chk("rw_timeout", timeout, 0);        chk("rw_proto", proto_err, 0);
    tick;
    chk("rw_m0_ack_count", n_m0ack, 0);
    req(0, 1, 32'h60, 32'hCAFE, 3'b010); tick; drop;
    serve(32'h0000CAFE, w);
    chk("rw_new_addr", seen_addr, 32'h60); chk("rw_new_we", seen_we, 1);
    chk("rw_new_ack", m0_bus.ack, 1);      chk("rw_new_data", m0_bus.rdata, 32'h0000CAFE);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
